intermediate_buffer: RTL and testbench
======================================

Name: intermediate_buffer

Overview:
- Staging buffer between two neural-network layers in the non-linear-equation accelerator.
- Captures the parallel outputs of all neurons (ALUs) of the previous layer in one cycle.
- Serialises them one floating-point word per clock toward the next layer.
- Raises a one-cycle capture acknowledge so the producing layer can release its outputs.

Parameters:
- NUM_NEURONS, 2: number of ALU outputs in the previous layer; must be >= 1.
- BIT_WIDTH, 32: floating-point word size in bits.
- EXTRA_BITS, 0: FloPoCo exception bits added to each word; only 0 or 2 are legal.
- Derived: W = BIT_WIDTH + EXTRA_BITS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- layer_output  input  NUM_NEURONS*W  packed neuron outputs; neuron i occupies bits [i*W +: W].
- inter_en  input  1  capture request; sampled on the rising edge of clk.
- shift_res  output  W  currently presented serial word.
- shift_valid  output  1  high while shift_res carries a word of the current vector.
- cap_ack  output  1  one-cycle pulse on capture.

Behaviour:
- Reset:
  - Asynchronous on rst=1.
  - shift_res=0, shift_valid=0, cap_ack=0, state=IDLE, internal buffer=0, word counter=0.
  - Reset asserted mid-shift aborts the vector; there is no resume.
- States: IDLE and SHIFT.
- Capture-eligible edge: any edge in IDLE, or the edge in SHIFT that follows presentation of the last word.
- At a capture-eligible edge with inter_en=1:
  - The full layer_output vector is latched.
  - shift_res <= neuron 0 word; shift_valid <= 1; cap_ack <= 1.
  - remaining <= NUM_NEURONS-1; state -> SHIFT.
  - Latency: first word is visible immediately after the capture edge.
- In SHIFT with remaining > 0, each edge: shift_res <= next neuron word (index ascending), remaining decrements, cap_ack <= 0.
- In SHIFT with remaining = 0, at the next edge:
  - inter_en=1: back-to-back capture as above, with no gap cycle.
  - inter_en=0: shift_valid <= 0, cap_ack <= 0, state -> IDLE; shift_res holds the last word.
- inter_en in SHIFT while remaining > 0 is ignored; layer_output changes are not sampled and cap_ack stays 0.
- A vector therefore occupies exactly NUM_NEURONS consecutive shift_valid cycles.
- NUM_NEURONS=1: each capture gives one valid cycle; a continuously held inter_en captures every cycle with cap_ack high every cycle.
- cap_ack is high only in the cycle after a capture edge.
- Data passes through unmodified with no arithmetic; EXTRA_BITS only widens the slices.
- Implementation: shift register or indexed mux, either is acceptable; the counter must be sized clog2(NUM_NEURONS)+1.

Optional Feature:
- Macro: INTER_BUF_MSB_FIRST_EN.
- Defined: serial order is reversed. Neuron NUM_NEURONS-1 (the most significant slice) is presented first, descending to neuron 0.
- Not defined: ascending order, neuron 0 first, as described in Behaviour.
- Timing, handshake and reset are identical in both modes.

Test Plan:
1. Reset, then check outputs:
   - rst pulse mid-simulation -> shift_res=0, shift_valid=0, cap_ack=0 immediately, without waiting for a clock.
2. Basic capture (NUM_NEURONS=2, W=32):
   - Stimulus: layer_output=64'hEEEEEEEE_AAAAAAAA, inter_en=1 for one edge.
   - Cycle 1: shift_res=AAAAAAAA, shift_valid=1, cap_ack=1.
   - Cycle 2: shift_res=EEEEEEEE, shift_valid=1, cap_ack=0.
   - Cycle 3: shift_valid=0, shift_res holds EEEEEEEE.
3. Ignore during shift:
   - Stimulus: after capture of EEEE…/AAAA…, layer_output=64'hFFFFFFFF_BBBBBBBB with inter_en=1 on the second word edge.
   - Second word remains EEEEEEEE and cap_ack stays 0.
   - The following edge captures: shift_res=BBBBBBBB, then FFFFFFFF, cap_ack pulses again.
4. Back-to-back:
   - Stimulus: inter_en held 1 with constant input 64'h11111111_22222222.
   - shift_res alternates 22222222, 11111111 continuously; shift_valid stays 1; cap_ack pulses every 2 cycles.
5. Reset mid-shift:
   - Stimulus: rst asserted after the first word.
   - Outputs clear at once; after release, the state is IDLE and no stale word appears.
6. Macro build:
   - INTER_BUF_MSB_FIRST_EN defined, scenario 2 repeated -> EEEEEEEE then AAAAAAAA.
   - EXTRA_BITS=2 (W=34) with NUM_NEURONS=3 -> three correct 34-bit slices.

Source files
------------

// File: rtl/intermediate_buffer.sv
// Layer-to-layer staging buffer: captures all neuron outputs in one cycle, then serialises them
// one word per clock. Define INTER_BUF_MSB_FIRST_EN to present the highest neuron slice first.
module intermediate_buffer #(
  parameter int unsigned NUM_NEURONS = 2,
  parameter int unsigned BIT_WIDTH   = 32,
  parameter int unsigned EXTRA_BITS  = 0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_NEURONS*(BIT_WIDTH+EXTRA_BITS)-1:0] layer_output,
  input  logic                                          inter_en,
  output logic [BIT_WIDTH+EXTRA_BITS-1:0]               shift_res,
  output logic                                          shift_valid,
  output logic                                          cap_ack
);

  localparam int unsigned W    = BIT_WIDTH + EXTRA_BITS;
  localparam int unsigned VecW = NUM_NEURONS * W;
  localparam int unsigned CntW = $clog2(NUM_NEURONS) + 1;

  if (NUM_NEURONS < 1 || (EXTRA_BITS != 0 && EXTRA_BITS != 2)) begin : gen_param_err
    $error("intermediate_buffer: illegal NUM_NEURONS or EXTRA_BITS");
  end

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [VecW-1:0]   buf_q, buf_d;
  logic [W-1:0]      res_q, res_d;
  logic              valid_q, valid_d;
  logic              ack_q, ack_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              cap_eligible;
  logic              capture;
  logic [W-1:0]      cap_word;
  logic [W-1:0]      buf_word;
  logic [VecW-1:0]   cap_rest;
  logic [VecW-1:0]   buf_rest;

  // The buffer only holds the words not yet presented; the next word is always at one end.
`ifdef INTER_BUF_MSB_FIRST_EN
  assign cap_word = layer_output[VecW-1 -: W];
  assign buf_word = buf_q[VecW-1 -: W];
  assign cap_rest = layer_output << W;
  assign buf_rest = buf_q << W;
`else
  assign cap_word = layer_output[0 +: W];
  assign buf_word = buf_q[0 +: W];
  assign cap_rest = layer_output >> W;
  assign buf_rest = buf_q >> W;
`endif

  assign cap_eligible = (state_q == StIdle) || (cnt_q == '0);
  assign capture      = cap_eligible && inter_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      buf_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (inter_en) state_d = StShift;
      StShift: if (cnt_q == '0 && !inter_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    buf_d   = buf_q;
    res_d   = res_q;
    valid_d = valid_q;
    ack_d   = 1'b0;
    cnt_d   = cnt_q;
    if (capture) begin
      buf_d   = cap_rest;
      res_d   = cap_word;
      valid_d = 1'b1;
      ack_d   = 1'b1;
      cnt_d   = CntW'(NUM_NEURONS - 1);
    end else if (state_q == StShift) begin
      if (cnt_q != '0) begin
        buf_d = buf_rest;
        res_d = buf_word;
        cnt_d = cnt_q - 1'b1;
      end else begin
        // Last word already shown and no new request: drop valid, hold the word.
        valid_d = 1'b0;
      end
    end
  end

  assign shift_res   = res_q;
  assign shift_valid = valid_q;
  assign cap_ack     = ack_q;

endmodule

// File: tb/tb_intermediate_buffer.sv
// Self-checking bench: two configurations (2x32 and 3x34) against a queue-based reference model.
module tb_intermediate_buffer;

  localparam int NA = 2;
  localparam int WA = 32;
  localparam int NB = 3;
  localparam int WB = 34;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [NA*WA-1:0] lo_a = '0;
  logic             en_a = 1'b0;
  logic [WA-1:0]    res_a;
  logic             val_a, ack_a;

  logic [NB*WB-1:0] lo_b = '0;
  logic             en_b = 1'b0;
  logic [WB-1:0]    res_b;
  logic             val_b, ack_b;

  always #5 clk = ~clk;

  intermediate_buffer #(.NUM_NEURONS(NA), .BIT_WIDTH(32), .EXTRA_BITS(0)) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .layer_output (lo_a),
    .inter_en     (en_a),
    .shift_res    (res_a),
    .shift_valid  (val_a),
    .cap_ack      (ack_a)
  );

  intermediate_buffer #(.NUM_NEURONS(NB), .BIT_WIDTH(32), .EXTRA_BITS(2)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .layer_output (lo_b),
    .inter_en     (en_b),
    .shift_res    (res_b),
    .shift_valid  (val_b),
    .cap_ack      (ack_b)
  );

  int checks = 0;
  int errors = 0;

  // Model: queue of words still to be presented after the current one.
  logic [WA-1:0] qa[$];
  logic [WA-1:0] ea_res;
  logic          ea_val, ea_ack;
  logic [WB-1:0] qb[$];
  logic [WB-1:0] eb_res;
  logic          eb_val, eb_ack;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int order(input int k, input int n);
`ifdef INTER_BUF_MSB_FIRST_EN
    return n - 1 - k;
`else
    return k;
`endif
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    ea_res = '0; ea_val = 1'b0; ea_ack = 1'b0;
    eb_res = '0; eb_val = 1'b0; eb_ack = 1'b0;
  endtask

  task automatic model_edge();
    logic [WA-1:0] wa;
    logic [WB-1:0] wb;
    if (qa.size() == 0) begin
      if (en_a) begin
        for (int k = 0; k < NA; k++) begin
          wa = lo_a[order(k, NA)*WA +: WA];
          if (k == 0) ea_res = wa;
          else qa.push_back(wa);
        end
        ea_val = 1'b1;
        ea_ack = 1'b1;
      end else begin
        ea_val = 1'b0;
        ea_ack = 1'b0;
      end
    end else begin
      ea_res = qa.pop_front();
      ea_ack = 1'b0;
    end
    if (qb.size() == 0) begin
      if (en_b) begin
        for (int k = 0; k < NB; k++) begin
          wb = lo_b[order(k, NB)*WB +: WB];
          if (k == 0) eb_res = wb;
          else qb.push_back(wb);
        end
        eb_val = 1'b1;
        eb_ack = 1'b1;
      end else begin
        eb_val = 1'b0;
        eb_ack = 1'b0;
      end
    end else begin
      eb_res = qb.pop_front();
      eb_ack = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("a_res", 64'(res_a), 64'(ea_res));
    check("a_valid", 64'(val_a), 64'(ea_val));
    check("a_ack", 64'(ack_a), 64'(ea_ack));
    check("b_res", 64'(res_b), 64'(eb_res));
    check("b_valid", 64'(val_b), 64'(eb_val));
    check("b_ack", 64'(ack_b), 64'(eb_ack));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_res_a", 64'(res_a), 64'd0);
    check("rst_valid_a", 64'(val_a), 64'd0);
    check("rst_ack_a", 64'(ack_a), 64'd0);
    compare_all();
    #2;
    rst = 1'b0;
  endtask

  logic [WA-1:0]  w_first, w_second;
  logic [127:0]   rnd_b;

  initial begin
`ifdef INTER_BUF_MSB_FIRST_EN
    w_first = 32'hEEEEEEEE; w_second = 32'hAAAAAAAA;
`else
    w_first = 32'hAAAAAAAA; w_second = 32'hEEEEEEEE;
`endif
    #1;
    do_reset();
    step();

    // Basic capture
    lo_a = 64'hEEEEEEEE_AAAAAAAA; en_a = 1'b1;
    step();
    check("s2_w0", 64'(res_a), 64'(w_first));
    check("s2_ack0", 64'(ack_a), 64'd1);
    en_a = 1'b0;
    step();
    check("s2_w1", 64'(res_a), 64'(w_second));
    check("s2_ack1", 64'(ack_a), 64'd0);
    step();
    check("s2_idle_valid", 64'(val_a), 64'd0);
    check("s2_hold", 64'(res_a), 64'(w_second));
    step();

    // Request during shift is ignored, then captured on the following edge
    lo_a = 64'hEEEEEEEE_AAAAAAAA; en_a = 1'b1;
    step();
    lo_a = 64'hFFFFFFFF_BBBBBBBB;
    step();
    check("s3_ignored_word", 64'(res_a), 64'(w_second));
    check("s3_ignored_ack", 64'(ack_a), 64'd0);
    step();
    check("s3_recap_ack", 64'(ack_a), 64'd1);
    en_a = 1'b0;
    step();
    step();

    // Back-to-back, plus a 3x34 vector on the other instance
    lo_a = 64'h11111111_22222222; en_a = 1'b1;
    lo_b = {34'h3_0000_0003, 34'h2_0000_0002, 34'h1_0000_0001}; en_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("s4_valid", 64'(val_a), 64'd1);
    end
    en_a = 1'b0; en_b = 1'b0;
    step();
    step();
    step();

    // Reset mid-shift
    lo_a = 64'hCAFEF00D_12345678; en_a = 1'b1;
    lo_b = {34'h2_1234_5678, 34'h1_DEAD_BEEF, 34'h3_0BAD_CAFE}; en_b = 1'b1;
    step();
    en_a = 1'b0; en_b = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check("s5_no_stale", 64'(res_a), 64'd0);
    end

    // Randomised traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      en_a  = ($urandom_range(0, 2) != 0);
      en_b  = ($urandom_range(0, 3) != 0);
      lo_a  = {$urandom, $urandom};
      rnd_b = {$urandom, $urandom, $urandom, $urandom};
      lo_b  = rnd_b[NB*WB-1:0];
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
